serial_word_tx: RTL
===================

Name: serial_word_tx

Overview:
- Transmit end of the team's serial two's-complement datapath.
- Accepts a parallel WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first on a 1-bit serial line.
- Drives a word-start strobe high on the first bit of every word, exactly the (i, r) pair the serial complementer consumes.
- Lets benches and upstream logic feed the complementer from parallel words instead of hand-written bit sequences.

Parameters:
- WIDTH, 12, data bits per word (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, do not override.

Ports:
- t_clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- din  in  WIDTH  parallel word to send; bit 0 is sent first.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  transmitter can take a word this cycle.
- i  out  1  serial data bit, registered.
- r  out  1  word-start strobe, registered; high only while i carries bit 0.
- busy  out  1  a word (or its parity bit) is on the line.
- done  out  1  one-cycle pulse while the final bit of a word is on the line.

Behaviour:
- Reset: when rst_n=0 at an edge, state=IDLE and the shift register and counter clear. Outputs go to i=0, r=0, busy=0, done=0, din_ready=1.
- Reset mid-word aborts the word with no further bits and no done pulse. The word is not retransmitted.
- Handshake: a word is accepted on an edge where din_valid && din_ready. din is sampled only then.
- din_ready is combinational:
  - 1 in IDLE;
  - 1 in the cycle whose line bit is the final bit of the current word;
  - 0 otherwise.
- Latency: bit 0 appears on i, with r=1, in the cycle after acceptance. Bit k appears k cycles after bit 0.
- States:
  - IDLE: i=0, r=0, busy=0. On acceptance: load din, counter=0, go to SHIFT.
  - SHIFT: i=shreg[0], r=(counter==0), busy=1. Each edge shifts right and increments counter.
  - At counter==WIDTH-1, done=1 that cycle. The next state is:
    - LOAD (re-enter SHIFT with counter=0) if a new word is accepted on that edge;
    - PARITY if the parity feature is compiled in;
    - otherwise IDLE.
  - PARITY (feature only): i=parity bit, r=0, busy=1, done=1. din_ready=1; accepting here re-enters SHIFT, otherwise go to IDLE.
- Back-to-back words: with din_valid held high, words stream with no gap cycle. r pulses every WIDTH cycles (WIDTH+1 with parity).
- din_valid dropping while not ready has no effect. Holding din between handshakes is not required.
- Simultaneous reset and acceptance: reset wins.

Optional Feature:
- Macro SERIAL_WORD_TX_PARITY_EN.
- Defined: after bit WIDTH-1, one extra cycle carries the even-parity bit (XOR of all WIDTH data bits). done moves to that cycle, and the word period is WIDTH+1.
- Undefined: no PARITY state and a word period of WIDTH. done is high on the bit WIDTH-1 cycle.

Decomposition:
- Shared package serial_pkg holds:
  - state enum tx_state_t {IDLE, SHIFT, PARITY};
  - localparam SER_WORD_W=12, the default width shared with the complementer and its receiver;
  - function even_parity().
- One natural sub-module: serial_bit_counter, a modulo counter with terminal-count flag, reusable by the matching deserializer.
- The shift register and FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with din_valid=1 → i=0, r=0, busy=0, din_ready=1. No acceptance during reset.
- Single word (WIDTH=12): din=12'hD2A, one-cycle valid → next 12 cycles i=0,1,0,1,0,1,0,0,1,0,1,1. r=1 only in the first of them, done=1 in the 12th, then IDLE with busy=0.
- Back-to-back: valid held with 12'h001 then 12'hFFF → r pulses exactly 12 cycles apart. i=1 then eleven 0s, then twelve 1s, with no gap cycle. din_ready=1 only in the final-bit cycles.
- Mid-word reset: rst_n=0 at bit 5 of 12'hFFF → the next edge gives i=0, r=0, busy=0, no done pulse. A new word afterwards starts cleanly with r=1.
- Chained with the complementer: send 12'h005 → complementer y stream reassembles to 12'hFFB. Send 12'h800 → 12'h800.
- With SERIAL_WORD_TX_PARITY_EN: din=12'h007 → the 13th bit is 1 and done is high in cycle 13. din=12'h003 → the 13th bit is 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial two's-complement datapath.
// Contents:
//   SER_WORD_W  - default word width shared by transmitter, complementer and receiver
//   tx_state_t  - transmitter state encoding
//   even_parity - XOR reduction of a word, zero-extended to 64 bits
package serial_pkg;

  localparam int unsigned SER_WORD_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  // Zero-extension does not change the XOR, so any word up to 64 bits may be passed.
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Parallel-in / serial-out bundle of the word transmitter.
// Signals:
//   din, din_valid  - parallel word and its valid (source -> transmitter)
//   din_ready       - transmitter can take a word this cycle
//   i, r            - serial data bit and word-start strobe
//   busy, done      - word on the line / final bit of the word on the line
// Modports: master = word source and line observer, slave = transmitter.
interface serial_word_tx_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WORD_W
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             i;
  logic             r;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, i, r, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, i, r, busy, done
  );

endinterface

// File: rtl/serial_bit_counter.sv
// Modulo-Modulus bit counter with terminal-count flag.
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset, clears the count
//   clr_i   - synchronous clear to zero (wins over en_i)
//   en_i    - advance by one, wrapping after Modulus-1
//   cnt_o   - current count
//   tc_o    - count equals Modulus-1
module serial_bit_counter #(
  parameter int unsigned Modulus = 12,
  parameter int unsigned CntW    = $clog2(Modulus + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CntW'(Modulus - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Serial word transmitter: takes a WIDTH-bit word over valid/ready and shifts it
// out LSB-first on i, with r high on bit 0 of every word.
// Ports:
//   t_clk  - clock, rising edge
//   rst_n  - synchronous active-low reset
//   tx     - serial_word_tx_if.slave (din, din_valid, din_ready, i, r, busy, done)
// Option: define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit after
// bit WIDTH-1; done then moves to the parity cycle and the word period is WIDTH+1.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WORD_W
) (
  input logic                t_clk,
  input logic                rst_n,
  serial_word_tx_if.slave    tx
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StShift  = SHIFT;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam logic [1:0] StParity = PARITY;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             ready;
  logic             accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready only while idle or while the final line bit of the current word is out,
  // so back-to-back words follow with no gap cycle.
`ifdef SERIAL_WORD_TX_PARITY_EN
  assign ready = (state_q == StIdle) || (state_q == StParity);
`else
  assign ready = (state_q == StIdle) || ((state_q == StShift) && tc);
`endif
  assign accept       = tx.din_valid && ready;
  assign tx.din_ready = ready;

  serial_bit_counter #(
    .Modulus (WIDTH),
    .CntW    (CNT_W)
  ) u_bit_counter (
    .clk_i  (t_clk),
    .rst_ni (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == StShift),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
    par_d   = par_q;
`endif
    tx.i    = 1'b0;
    tx.r    = 1'b0;
    tx.busy = 1'b0;
    tx.done = 1'b0;
    case (state_q)
      StShift: begin
        tx.i    = shreg_q[0];
        tx.r    = (cnt == '0);
        tx.busy = 1'b1;
        shreg_d = shreg_q >> 1;
        if (tc) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
          state_d = StParity;
`else
          tx.done = 1'b1;
          state_d = StIdle;
`endif
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      StParity: begin
        tx.i    = par_q;
        tx.busy = 1'b1;
        tx.done = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    // Acceptance overrides the state-specific next state (load from any ready state).
    if (accept) begin
      state_d = StShift;
      shreg_d = tx.din;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_d   = even_parity(64'(tx.din));
`endif
    end
  end

  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
